// File: rtl/conv_hard_decoder.sv
// Hard-decision inverse decoder for the tail-biting rate-1/3, K=7 convolutional code (133/171/165).
// Recovers data bits from d0 and the running history, checks d1/d2, and packs the bits LSB-first into bytes.
module conv_hard_decoder #(
  parameter int K_SMALL = 1056,
  parameter int K_LARGE = 6144,
  parameter int CNT_W   = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       meta_data,
  input  logic             meta_empty,
  output logic             meta_rdreq,
  input  logic [2:0]       enc_data,
  input  logic             enc_empty,
  output logic             enc_rdreq,
  output logic [7:0]       out_data,
  output logic             out_wrreq,
  input  logic             out_full,
  output logic             blk_done,
  output logic             tb_err,
  output logic [CNT_W-1:0] bit_err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic [5:0]       hist_r;       // [5] = s1 (most recent bit) ... [0] = s6
  logic [5:0]       init_r;
  logic             large_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [7:0]       byte_r;
  logic             pop_s;
  logic             u_s;
  logic [1:0]       par_s;
  logic             err_s;
  logic             last_s;
  logic [5:0]       hist_nx_s;
  logic             unused_meta_s;

  // Data bit recovered from d0: invert the 133 generator using the known history.
  function automatic logic recover_bit(input logic d0, input logic [5:0] s);
    return d0 ^ s[4] ^ s[3] ^ s[1] ^ s[0];
  endfunction

  // Re-encoded {p1, p2} for generators 171 and 165.
  function automatic logic [1:0] parity_pair(input logic u, input logic [5:0] s);
    return {u ^ s[5] ^ s[4] ^ s[3] ^ s[0], u ^ s[5] ^ s[4] ^ s[2] ^ s[0]};
  endfunction

  assign unused_meta_s = meta_data[1];
  assign meta_rdreq    = (state_r == LOAD);
  assign enc_rdreq     = pop_s;

  // Pop decision, bit recovery and parity check for the triple at the FIFO head.
  always_comb begin
    pop_s     = (state_r == RUN) && !enc_empty && !out_full;
    u_s       = recover_bit(enc_data[2], hist_r);
    par_s     = parity_pair(u_s, hist_r);
    err_s     = (par_s != enc_data[1:0]);
    hist_nx_s = {u_s, hist_r[5:1]};
    if (large_r) begin
      last_s = (bit_cnt_r == CNT_W'(K_LARGE - 1));
    end else begin
      last_s = (bit_cnt_r == CNT_W'(K_SMALL - 1));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (!meta_empty) state_nx_s = LOAD;
        else             state_nx_s = IDLE;
      end
      LOAD: state_nx_s = RUN;
      RUN: begin
        if (pop_s && last_s) state_nx_s = DONE;
        else                 state_nx_s = RUN;
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Datapath: history, byte packing, error count and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_r      <= 6'd0;
      init_r      <= 6'd0;
      large_r     <= 1'b0;
      bit_cnt_r   <= {CNT_W{1'b0}};
      byte_r      <= 8'd0;
      out_data    <= 8'd0;
      out_wrreq   <= 1'b0;
      blk_done    <= 1'b0;
      tb_err      <= 1'b0;
      bit_err_cnt <= {CNT_W{1'b0}};
    end else begin
      out_wrreq <= 1'b0;
      blk_done  <= 1'b0;
      case (state_r)
        LOAD: begin
          hist_r      <= meta_data[7:2];
          init_r      <= meta_data[7:2];
          large_r     <= meta_data[0];
          bit_cnt_r   <= {CNT_W{1'b0}};
          bit_err_cnt <= {CNT_W{1'b0}};
          tb_err      <= 1'b0;
        end
        RUN: begin
          if (pop_s) begin
            hist_r                 <= hist_nx_s;
            byte_r[bit_cnt_r[2:0]] <= u_s;
            bit_cnt_r              <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (err_s && (bit_err_cnt != {CNT_W{1'b1}})) begin
              bit_err_cnt <= bit_err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (bit_cnt_r[2:0] == 3'd7) begin
              out_data  <= {u_s, byte_r[6:0]};
              out_wrreq <= 1'b1;
            end
            if (last_s) begin
              blk_done <= 1'b1;
              tb_err   <= (hist_nx_s != init_r);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_hard_decoder.sv
// Randomized bench for conv_hard_decoder: encodes blocks with a sequence-level tail-biting model,
// drives show-ahead FIFO behaviour and checks bytes, block status and stall behaviour against the model.
module tb_conv_hard_decoder;
  localparam int K_SMALL = 1056;
  localparam int K_LARGE = 6144;
  localparam int CNT_W   = 13;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       meta_data;
  logic             meta_empty;
  logic             meta_rdreq;
  logic [2:0]       enc_data;
  logic             enc_empty;
  logic             enc_rdreq;
  logic [7:0]       out_data;
  logic             out_wrreq;
  logic             out_full;
  logic             blk_done;
  logic             tb_err;
  logic [CNT_W-1:0] bit_err_cnt;

  conv_hard_decoder #(.K_SMALL(K_SMALL), .K_LARGE(K_LARGE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .meta_data(meta_data), .meta_empty(meta_empty),
    .meta_rdreq(meta_rdreq), .enc_data(enc_data), .enc_empty(enc_empty),
    .enc_rdreq(enc_rdreq), .out_data(out_data), .out_wrreq(out_wrreq),
    .out_full(out_full), .blk_done(blk_done), .tb_err(tb_err), .bit_err_cnt(bit_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tb_err;
    int errs;
    int nbytes;
  } blk_t;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_bytes[$];
  blk_t       exp_blk[$];
  int         rx_bytes = 0;
  int         blk_seen = 0;

  bit         data_b[K_LARGE];
  bit         dec_v[K_LARGE];
  logic [2:0] trip[K_LARGE];
  logic [7:0] cur_meta;
  int         model_tb_err;
  int         model_errs;
  int         model_src_diff;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Source bit j positions before bit i, wrapping around the block (tail-biting).
  function automatic bit hd(input int i, input int j, input int k);
    return data_b[(i - j + k) % k];
  endfunction

  // Decoded bit j positions before bit i; before the block start it comes from the meta tail bits.
  function automatic bit hv(input int i, input int j);
    if (i - j >= 0) return dec_v[i - j];
    return cur_meta[8 - (j - i)];
  endfunction

  task automatic gen_data(input int k, input int mode);
    for (int i = 0; i < k; i++) begin
      case (mode)
        0:       data_b[i] = 1'b0;
        1:       data_b[i] = (i == 0);
        default: data_b[i] = bit'($urandom & 1);
      endcase
    end
  endtask

  task automatic encode(input int k);
    for (int i = 0; i < k; i++) begin
      trip[i] = {data_b[i] ^ hd(i,2,k) ^ hd(i,3,k) ^ hd(i,5,k) ^ hd(i,6,k),
                 data_b[i] ^ hd(i,1,k) ^ hd(i,2,k) ^ hd(i,3,k) ^ hd(i,6,k),
                 data_b[i] ^ hd(i,1,k) ^ hd(i,2,k) ^ hd(i,4,k) ^ hd(i,6,k)};
    end
    for (int m = 1; m <= 6; m++) cur_meta[8 - m] = data_b[k - m];
    cur_meta[1] = 1'b0;
    cur_meta[0] = (k == K_LARGE);
  endtask

  // Decode trip[] from cur_meta and queue the expected bytes and block status.
  task automatic expect_block(input int k);
    blk_t e;
    bit p1, p2;
    logic [7:0] b;
    model_errs = 0;
    model_src_diff = 0;
    for (int i = 0; i < k; i++) begin
      dec_v[i] = trip[i][2] ^ hv(i,2) ^ hv(i,3) ^ hv(i,5) ^ hv(i,6);
      p1 = dec_v[i] ^ hv(i,1) ^ hv(i,2) ^ hv(i,3) ^ hv(i,6);
      p2 = dec_v[i] ^ hv(i,1) ^ hv(i,2) ^ hv(i,4) ^ hv(i,6);
      if (p1 != trip[i][1] || p2 != trip[i][0]) model_errs++;
      if (dec_v[i] != data_b[i]) model_src_diff++;
    end
    for (int n = 0; n < k / 8; n++) begin
      for (int j = 0; j < 8; j++) b[j] = dec_v[8*n + j];
      exp_bytes.push_back(b);
    end
    model_tb_err = 0;
    for (int m = 1; m <= 6; m++) if (dec_v[k - m] != cur_meta[8 - m]) model_tb_err = 1;
    e.tb_err = model_tb_err;
    e.errs = model_errs;
    e.nbytes = k / 8;
    exp_blk.push_back(e);
  endtask

  // Single compare process: every written byte and every block-end status against the model.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_wrreq) begin
        if (exp_bytes.size() == 0) check("unexpected_byte", 1, 0);
        else check("byte", int'(out_data), int'(exp_bytes.pop_front()));
        rx_bytes++;
      end
      if (blk_done) begin
        if (exp_blk.size() == 0) begin
          check("unexpected_blk_done", 1, 0);
        end else begin
          blk_t e;
          e = exp_blk.pop_front();
          check("tb_err", int'(tb_err), e.tb_err);
          check("bit_err_cnt", int'(bit_err_cnt), e.errs);
          check("byte_count", rx_bytes, e.nbytes);
        end
        rx_bytes = 0;
        blk_seen++;
      end
    end
  end

  task automatic check_outputs_zero();
    check("rst_meta_rdreq", int'(meta_rdreq), 0);
    check("rst_enc_rdreq", int'(enc_rdreq), 0);
    check("rst_out_wrreq", int'(out_wrreq), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_blk_done", int'(blk_done), 0);
    check("rst_tb_err", int'(tb_err), 0);
    check("rst_bit_err_cnt", int'(bit_err_cnt), 0);
  endtask

  // Feed one block; abort_at > 0 asserts reset once that many triples have been popped.
  task automatic run_block(input int k, input int gap_pct, input bit full_window, input int abort_at);
    int idx = 0;
    int cyc = 0;
    int full_left = 0;
    bit full_done = 1'b0;
    bit meta_pending = 1'b1;
    bit pop;
    int start = blk_seen;
    int bound = 4 * k + 400;
    bit aborted = 1'b0;
    while (blk_seen == start && cyc < bound && !aborted) begin
      @(negedge clk);
      cyc++;
      meta_data = cur_meta;
      meta_empty = !meta_pending;
      if (full_window && !full_done && idx >= k / 2) begin
        full_left = 50;
        full_done = 1'b1;
      end
      out_full = (full_left > 0);
      if (full_left > 0) full_left--;
      enc_empty = ($urandom_range(99) < gap_pct) || (idx >= k);
      enc_data = (idx < k) ? trip[idx] : 3'b000;
      #1;
      if (out_full) check("rdreq_while_full", int'(enc_rdreq), 0);
      if (meta_rdreq) meta_pending = 1'b0;
      pop = enc_rdreq;
      @(posedge clk);
      if (pop) idx++;
      if (abort_at > 0 && idx == abort_at) aborted = 1'b1;
    end
    meta_empty = 1'b1;
    enc_empty = 1'b1;
    out_full = 1'b0;
    if (aborted) begin
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_outputs_zero();
      exp_bytes.delete();
      exp_blk.delete();
      rx_bytes = 0;
      reset = 1'b0;
    end else if (blk_seen == start) begin
      check("block_timeout", cyc, -1);
    end else begin
      repeat (3) @(negedge clk);
      check("hold_bit_err_cnt", int'(bit_err_cnt), model_errs);
      check("hold_tb_err", int'(tb_err), model_tb_err);
    end
  endtask

  initial begin
    reset = 1'b1;
    meta_data = 8'h00;
    meta_empty = 1'b1;
    enc_data = 3'b000;
    enc_empty = 1'b1;
    out_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero();
    reset = 1'b0;

    // 1: all-zero small block.
    gen_data(K_SMALL, 0);
    encode(K_SMALL);
    check("model_meta_zero", int'(cur_meta), 0);
    check("model_zero_triple", int'(trip[7]), 0);
    expect_block(K_SMALL);
    run_block(K_SMALL, 0, 1'b0, 0);

    // 2a: single leading one, zero tail; hand-derived triples pin the encoder model.
    gen_data(K_SMALL, 1);
    encode(K_SMALL);
    check("model_trip0", int'(trip[0]), 3'b111);
    check("model_trip1", int'(trip[1]), 3'b011);
    check("model_trip2", int'(trip[2]), 3'b111);
    expect_block(K_SMALL);
    check("model_first_byte", int'(exp_bytes[0]), 8'h01);
    run_block(K_SMALL, 0, 1'b0, 0);

    // 2b: random large block.
    gen_data(K_LARGE, 2);
    encode(K_LARGE);
    expect_block(K_LARGE);
    check("model_src_match", model_src_diff, 0);
    run_block(K_LARGE, 0, 1'b0, 0);

    // 3: d1 of triple 5 flipped.
    trip[5][1] = ~trip[5][1];
    expect_block(K_LARGE);
    check("model_one_err", model_errs, 1);
    check("model_flip_src_match", model_src_diff, 0);
    run_block(K_LARGE, 0, 1'b0, 0);
    trip[5][1] = ~trip[5][1];

    // 4: tail bit s1 corrupted in the metadata.
    cur_meta[7] = ~cur_meta[7];
    expect_block(K_LARGE);
    check("model_tb_err", model_tb_err, 1);
    run_block(K_LARGE, 0, 1'b0, 0);
    cur_meta[7] = ~cur_meta[7];

    // 5: random empty gaps plus a 50-cycle out_full window.
    gen_data(K_LARGE, 2);
    encode(K_LARGE);
    expect_block(K_LARGE);
    run_block(K_LARGE, 25, 1'b1, 0);

    // 6: reset at bit 300 of a small block, then a fresh block.
    gen_data(K_SMALL, 2);
    encode(K_SMALL);
    expect_block(K_SMALL);
    run_block(K_SMALL, 10, 1'b0, 300);
    gen_data(K_SMALL, 2);
    encode(K_SMALL);
    expect_block(K_SMALL);
    check("model_fresh_src_match", model_src_diff, 0);
    run_block(K_SMALL, 10, 1'b0, 0);

    repeat (5) @(negedge clk);
    check("leftover_bytes", exp_bytes.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
